// File: rtl/hdr_sync_pkg.sv
// Shared types, header codes and seeker position helpers for the 66b block-header aligner.
package hdr_sync_pkg;

  localparam logic [1:0] DATA_HDR   = 2'b01;
  localparam logic [1:0] CMD_HDR    = 2'b10;
  localparam int         N_SEEK_DEF = 3;
  localparam int         POS_W      = 7;

  typedef enum logic {SEARCH, LOCKED} sync_state_e;

  // Bit position covered by seeker k at index j.
  function automatic int seek_pos(input int k, input int j, input int n_seek = N_SEEK_DEF);
    return k + 1 + n_seek * j;
  endfunction

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == DATA_HDR) || (hdr == CMD_HDR);
  endfunction

endpackage

// File: rtl/hdr_seek_lane.sv
// One header seeker: walks its interleaved set of positions until it sits on a run of valid headers.
module hdr_seek_lane
  import hdr_sync_pkg::*;
#(
  parameter int K       = 0,
  parameter int N_SEEK  = 3,
  parameter int BLOCK_W = 66,
  parameter int CNT_W   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [BLOCK_W:0]   i_window,
  input  logic               i_win_vld,
  input  logic               i_clear,
  input  logic               i_freeze,
  output logic [POS_W-1:0]   o_pos,
  output logic [CNT_W-1:0]   o_cnt
);

  localparam int N_IDX = BLOCK_W / N_SEEK;
  localparam int IDX_W = (N_IDX > 1) ? $clog2(N_IDX) : 1;

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [POS_W-1:0] w_pos_cur;
  logic             w_hdr_ok;

  assign w_pos_cur = POS_W'(seek_pos(K, int'(r_idx), N_SEEK));
  assign w_hdr_ok  = hdr_valid(i_window[w_pos_cur -: 2]);

  always_comb begin
    w_idx_next = r_idx;
    w_cnt_next = r_cnt;
    if (i_clear) begin
      w_idx_next = '0;
      w_cnt_next = '0;
    end else if (i_win_vld && !i_freeze) begin
      if (w_hdr_ok) begin
        if (r_cnt != '1) w_cnt_next = r_cnt + 1'b1;
      end else begin
        w_cnt_next = '0;
        w_idx_next = (r_idx == IDX_W'(N_IDX - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      r_idx <= w_idx_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Post-update view, so the top can lock on the same edge a count reaches its threshold.
  assign o_pos = POS_W'(seek_pos(K, int'(w_idx_next), N_SEEK));
  assign o_cnt = w_cnt_next;

endmodule

// File: rtl/hdr_block_sync.sv
// 66b block-header aligner: parallel seekers in SEARCH, frozen offset with error-window monitor in LOCKED.
module hdr_block_sync
  import hdr_sync_pkg::*;
#(
  parameter int BUF_W    = 194,
  parameter int BLOCK_W  = 66,
  parameter int N_SEEK   = 3,
  parameter int CNT_W    = 6,
  parameter int LOCK_CNT = 32,
  parameter int BAD_WIN  = 64,
  parameter int BAD_MAX  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BUF_W-1:0] gbox_buffer_i,
  input  logic [5:0]       gbox_cnt_i,
  input  logic             buffer_dv_i,
  input  logic             resync_i,
  output logic [6:0]       block_offset_o,
  output logic             block_lock_o,
  output logic             lock_loss_o,
  output logic [CNT_W-1:0] hdr_err_cnt_o
);

  localparam int WIN_W  = BLOCK_W + 1;
  localparam int BASE_W = $clog2(BUF_W);
  localparam int SMP_W  = (BAD_WIN > 1) ? $clog2(BAD_WIN) : 1;

  sync_state_e      r_state;
  logic [WIN_W-1:0] r_window;
  logic             r_win_vld;
  logic [POS_W-1:0] r_lock_pos;
  logic [POS_W-1:0] r_offset;
  logic             r_lock;
  logic             r_lock_loss;
  logic [CNT_W-1:0] r_err_cnt;
  logic [SMP_W-1:0] r_smp_cnt;

  logic [BASE_W-1:0] w_base;
  logic [WIN_W-1:0]  w_window;
  logic [POS_W-1:0]  w_pos [N_SEEK];
  logic [CNT_W-1:0]  w_cnt [N_SEEK];
  logic [POS_W-1:0]  w_lead_pos;
  logic [CNT_W-1:0]  w_lead_cnt;
  logic [POS_W-1:0]  w_hit_pos;
  logic              w_hit;
  logic              w_bad;
  logic [CNT_W-1:0]  w_err_inc;
  logic              w_lose;
  logic              w_clear;
  logic              w_freeze;

  assign w_base   = BASE_W'(BUF_W - 1) - BASE_W'(gbox_cnt_i);
  assign w_window = gbox_buffer_i[w_base -: WIN_W];

  assign w_bad     = !hdr_valid(r_window[r_lock_pos -: 2]);
  assign w_err_inc = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
  // Error threshold is evaluated before the window wrap, so a wrap edge cannot mask a lock loss.
  assign w_lose    = (r_state == LOCKED) && r_win_vld && w_bad && (w_err_inc == CNT_W'(BAD_MAX));
  assign w_clear   = resync_i || w_lose;
  assign w_freeze  = (r_state == LOCKED);

  for (genvar gi = 0; gi < N_SEEK; gi++) begin : g_lane
    hdr_seek_lane #(
      .K       (gi),
      .N_SEEK  (N_SEEK),
      .BLOCK_W (BLOCK_W),
      .CNT_W   (CNT_W)
    ) u_lane (
      .i_clk     (clk_i),
      .i_rst_n   (rst_ni),
      .i_window  (r_window),
      .i_win_vld (r_win_vld),
      .i_clear   (w_clear),
      .i_freeze  (w_freeze),
      .o_pos     (w_pos[gi]),
      .o_cnt     (w_cnt[gi])
    );
  end

  // Leader needs a strictly larger count to take over, so ties stay with the lowest seeker.
  always_comb begin
    w_lead_pos = w_pos[0];
    w_lead_cnt = w_cnt[0];
    w_hit      = 1'b0;
    w_hit_pos  = w_pos[0];
    for (int k = 0; k < N_SEEK; k++) begin
      if (w_cnt[k] > w_lead_cnt) begin
        w_lead_cnt = w_cnt[k];
        w_lead_pos = w_pos[k];
      end
      if (!w_hit && (w_cnt[k] == CNT_W'(LOCK_CNT))) begin
        w_hit     = 1'b1;
        w_hit_pos = w_pos[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= SEARCH;
      r_window    <= '0;
      r_win_vld   <= 1'b0;
      r_lock_pos  <= '0;
      r_offset    <= '0;
      r_lock      <= 1'b0;
      r_lock_loss <= 1'b0;
      r_err_cnt   <= '0;
      r_smp_cnt   <= '0;
    end else begin
      r_win_vld   <= buffer_dv_i;
      r_lock_loss <= 1'b0;
      if (buffer_dv_i) r_window <= w_window;
      if (resync_i) begin
        r_state   <= SEARCH;
        r_lock    <= 1'b0;
        r_err_cnt <= '0;
        r_smp_cnt <= '0;
      end else if (r_win_vld) begin
        case (r_state)
          SEARCH: begin
            r_offset <= w_lead_pos - POS_W'(1);
            if (w_hit) begin
              r_state    <= LOCKED;
              r_lock_pos <= w_hit_pos;
              r_offset   <= w_hit_pos - POS_W'(1);
              r_lock     <= 1'b1;
              r_err_cnt  <= '0;
              r_smp_cnt  <= '0;
            end
          end
          LOCKED: begin
            if (w_lose) begin
              r_state     <= SEARCH;
              r_lock      <= 1'b0;
              r_lock_loss <= 1'b1;
              r_err_cnt   <= '0;
              r_smp_cnt   <= '0;
            end else if (r_smp_cnt == SMP_W'(BAD_WIN - 1)) begin
              r_smp_cnt <= '0;
              r_err_cnt <= '0;
            end else begin
              r_smp_cnt <= r_smp_cnt + 1'b1;
              if (w_bad) r_err_cnt <= w_err_inc;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign block_offset_o = r_offset;
  assign block_lock_o   = r_lock;
  assign lock_loss_o    = r_lock_loss;
  assign hdr_err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_hdr_block_sync.sv
// Directed bench for hdr_block_sync: exact lock timing, error-window hysteresis, gapped dv, resync and reset.
module tb_hdr_block_sync;

  localparam int BUF_W = 194;
  localparam int CNT_W = 6;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [BUF_W-1:0] gbox_buffer_i;
  logic [5:0]       gbox_cnt_i;
  logic             buffer_dv_i;
  logic             resync_i;
  logic [6:0]       block_offset_o;
  logic             block_lock_o;
  logic             lock_loss_o;
  logic [CNT_W-1:0] hdr_err_cnt_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          gcnt = 0;
  int          loss_pulses = 0;
  logic [30:0] prbs_st = 31'h1234567;

  hdr_block_sync u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .gbox_buffer_i  (gbox_buffer_i),
    .gbox_cnt_i     (gbox_cnt_i),
    .buffer_dv_i    (buffer_dv_i),
    .resync_i       (resync_i),
    .block_offset_o (block_offset_o),
    .block_lock_o   (block_lock_o),
    .lock_loss_o    (lock_loss_o),
    .hdr_err_cnt_o  (hdr_err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (rst_ni && lock_loss_o) loss_pulses++;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Header 01 at [p:p-1]; ones below it and zeros above so no other position looks valid.
  task automatic mk_win(input int p, input logic good, output logic [66:0] w);
    for (int i = 0; i < 67; i++) w[i] = (i < p - 1) ? 1'b1 : 1'b0;
    w[p-1] = good;
    w[p]   = 1'b0;
  endtask

  task automatic prbs_win(output logic [66:0] w);
    logic fb;
    for (int i = 0; i < 67; i++) begin
      fb      = prbs_st[30] ^ prbs_st[27];
      prbs_st = {prbs_st[29:0], fb};
      w[i]    = fb;
    end
  endtask

  task automatic send(input logic [66:0] w, input logic dv);
    logic [BUF_W-1:0] b;
    for (int i = 0; i < BUF_W; i++) b[i] = 1'($urandom);
    b[BUF_W-1-gcnt -: 67] = w;
    gbox_buffer_i = b;
    gbox_cnt_i    = 6'(gcnt);
    buffer_dv_i   = dv;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    logic [66:0] w;
    for (int i = 0; i < 67; i++) w[i] = 1'($urandom);
    send(w, 1'b0);
  endtask

  task automatic check_refl(input int refl, input int n_lock, input int off, input string tag);
    if (refl == n_lock - 1) chk({tag, "_lock_pre"}, block_lock_o, 0);
    if (refl == n_lock) begin
      chk({tag, "_lock_at"}, block_lock_o, 1);
      chk({tag, "_offset"}, block_offset_o, off);
      chk({tag, "_loss"}, lock_loss_o, 0);
    end
  endtask

  // Sends n_lock+1 good samples with 'gap' idle cycles after each; the lock must land exactly on n_lock.
  task automatic lock_run(input int p, input int n_lock, input int gap, input string tag);
    logic [66:0] w;
    for (int s = 1; s <= n_lock + 1; s++) begin
      mk_win(p, 1'b1, w);
      send(w, 1'b1);
      if (gap == 0) begin
        check_refl(s - 1, n_lock, p - 1, tag);
      end else begin
        idle();
        check_refl(s, n_lock, p - 1, tag);
        for (int g = 1; g < gap; g++) idle();
        if (s == n_lock) begin
          chk({tag, "_idle_hold_lock"}, block_lock_o, 1);
          chk({tag, "_idle_hold_off"}, block_offset_o, p - 1);
        end
      end
    end
  endtask

  initial begin
    logic [66:0] w;
    bit          seen;

    rst_ni        = 1'b0;
    resync_i      = 1'b0;
    buffer_dv_i   = 1'b0;
    gbox_cnt_i    = '0;
    gbox_buffer_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_offset", block_offset_o, 0);
    chk("rst_lock", block_lock_o, 0);
    chk("rst_loss", lock_loss_o, 0);
    chk("rst_err", hdr_err_cnt_o, 0);
    rst_ni = 1'b1;

    // Seeker 2 steps idx 0..5 (6 misses), then 32 hits: lock on sample 38.
    lock_run(21, 38, 0, "p21");

    // Window 1: sample 1 was the last good one above; samples 2..16 bad.
    for (int m = 2; m <= 64; m++) begin
      mk_win(21, !(m >= 2 && m <= 16), w);
      send(w, 1'b1);
      if (m - 1 == 16) chk("win1_err15", hdr_err_cnt_o, 15);
      if (m - 1 == 63) begin
        chk("win1_err_end", hdr_err_cnt_o, 15);
        chk("win1_lock_end", block_lock_o, 1);
      end
    end
    // Window 2: samples 10..25 bad, 16th bad drops lock; then relock 6+32 samples later.
    for (int n = 1; n <= 64; n++) begin
      mk_win(21, !(n >= 10 && n <= 25), w);
      send(w, 1'b1);
      if (n == 1) begin
        chk("wrap_err0", hdr_err_cnt_o, 0);
        chk("wrap_lock", block_lock_o, 1);
      end
      if (n - 1 == 24) begin
        chk("win2_err15", hdr_err_cnt_o, 15);
        chk("win2_lock15", block_lock_o, 1);
      end
      if (n - 1 == 25) begin
        chk("loss_pulse", lock_loss_o, 1);
        chk("loss_lock", block_lock_o, 0);
        chk("loss_err", hdr_err_cnt_o, 0);
        chk("loss_off_hold", block_offset_o, 20);
      end
      if (n - 1 == 26) chk("loss_pulse_end", lock_loss_o, 0);
      if (n - 1 == 62) chk("relock_pre", block_lock_o, 0);
      if (n - 1 == 63) begin
        chk("relock_at", block_lock_o, 1);
        chk("relock_off", block_offset_o, 20);
      end
    end

    resync_i = 1'b1;
    idle();
    resync_i = 1'b0;
    chk("resync_lock", block_lock_o, 0);
    chk("resync_loss", lock_loss_o, 0);

    // Last index of seeker 2 with a shifted window and 1-in-8 dv: 21 misses then 32 hits.
    gcnt = 5;
    lock_run(66, 53, 7, "p66gap");

    resync_i = 1'b1;
    idle();
    resync_i = 1'b0;
    gcnt = 0;
    seen = 1'b0;
    for (int s = 0; s < 1500 && !seen; s++) begin
      prbs_win(w);
      w[21] = 1'b0;
      w[20] = 1'b1;
      send(w, 1'b1);
      if (block_lock_o) seen = 1'b1;
    end
    chk("prbs_lock_seen", 32'(seen), 1);
    chk("prbs_offset", block_offset_o, 20);

    resync_i = 1'b1;
    idle();
    resync_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      mk_win(21, 1'b1, w);
      send(w, 1'b1);
    end
    chk("search_offset", block_offset_o, 12);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_offset", block_offset_o, 0);
    chk("arst_lock", block_lock_o, 0);
    chk("arst_err", hdr_err_cnt_o, 0);
    mk_win(21, 1'b1, w);
    send(w, 1'b1);
    send(w, 1'b1);
    chk("arst_hold_offset", block_offset_o, 0);
    buffer_dv_i = 1'b0;
    #2;
    rst_ni = 1'b1;
    lock_run(21, 38, 0, "post_rst");

    chk("loss_pulse_total", loss_pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
